// File: rtl/usr_pkg.sv
// Shared definitions for the parameterised shift register: mode codes and FSM state encoding.
// The rotate modes are only treated as real operations when USR_ROTATE_EN is defined.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // True for codes that step the register; everything else completes without stepping.
    function automatic logic is_shift_mode(input logic [2:0] m);
        logic r;
        r = (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ASR);
`ifdef USR_ROTATE_EN
        r = r || (m == MODE_ROL) || (m == MODE_ROR);
`endif
        return r;
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational one-bit step of the shift register datapath.
// Rotate cases are compiled in only when USR_ROTATE_EN is defined.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] d_next,
    output logic             out_bit
);

    always_comb begin
        d_next  = d;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                d_next  = {d[WIDTH-2:0], ser_in};
                out_bit = d[WIDTH-1];
            end
            MODE_SHR: begin
                d_next  = {ser_in, d[WIDTH-1:1]};
                out_bit = d[0];
            end
            MODE_ASR: begin
                d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
                out_bit = d[0];
            end
`ifdef USR_ROTATE_EN
            MODE_ROL: begin
                d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
                out_bit = d[WIDTH-1];
            end
            MODE_ROR: begin
                d_next  = {d[0], d[WIDTH-1:1]};
                out_bit = d[0];
            end
`endif
            default: begin
                d_next  = d;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// Multi-step shift/rotate register with an IDLE/SHIFT/DONE sequencer and clamped step counter.
// Define USR_ROTATE_EN to enable the ROL/ROR modes; otherwise those codes behave as HOLD.
module param_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] shift_amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    // Handshake: start is sampled only in IDLE; busy is high for each cycle a step is
    // pending, and done pulses for exactly one cycle after the final step (or after the
    // start edge for LOAD/HOLD/zero-length ops). start is ignored while busy or done.

    localparam logic [CNT_W-1:0] WIDTH_AMT = CNT_W'(WIDTH);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] amt_clamped;
    logic [WIDTH-1:0] step_d;
    logic             step_bit;

    assign amt_clamped = (shift_amt > WIDTH_AMT) ? WIDTH_AMT : shift_amt;
    assign dbg_state   = state;

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .d       (data_out),
        .mode    (mode_q),
        .ser_in  (ser_in),
        .d_next  (step_d),
        .out_bit (step_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mode_q   <= MODE_HOLD;
            data_out <= '0;
            ser_out  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        if (mode == MODE_LOAD) begin
                            data_out <= data_in;
                            cnt      <= '0;
                            state    <= ST_DONE;
                            done     <= 1'b1;
                        end else if (is_shift_mode(mode) && (amt_clamped != '0)) begin
                            cnt   <= amt_clamped;
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            cnt   <= '0;
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_out <= step_d;
                    ser_out  <= step_bit;
                    cnt      <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register at WIDTH=8.
// Rotate expectations follow USR_ROTATE_EN, matching the build of the design.
module tb_param_shift_register;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] mode;
    logic [3:0] shift_amt;
    logic [7:0] data_in;
    logic       ser_in;
    logic [7:0] data_out;
    logic       ser_out;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int n_cmp;
    int n_bad;

    param_shift_register #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .shift_amt (shift_amt),
        .data_in   (data_in),
        .ser_in    (ser_in),
        .data_out  (data_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: one start pulse, then watch until done has pulsed and dropped
    task automatic run_op(input logic [2:0] m, input logic [3:0] amt, input logic [7:0] din,
                          input logic sin, output int busy_n, output int done_n,
                          output logic first_done);
        bit seen;
        int cyc;
        busy_n = 0;
        done_n = 0;
        seen   = 0;
        @(negedge clk);
        start = 1'b1; mode = m; shift_amt = amt; data_in = din; ser_in = sin;
        @(negedge clk);
        start = 1'b0;
        first_done = done;
        for (cyc = 0; cyc < 64; cyc++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                seen = 1;
            end else if (seen) begin
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (cyc >= 64) begin
            n_bad++;
            $display("FAIL op_timeout mode=%b: no done within 64 cycles", m);
        end
    endtask

    task automatic test_reset();
        int bn, dn, dseen;
        logic fd;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: data=%h busy=%b done=%b ser=%b, need 00/0/0/0",
                     data_out, busy, done, ser_out);
        end
        reset = 1'b0;
        run_op(M_LOAD, 4'd0, 8'hFF, 1'b0, bn, dn, fd);
        // start SHR 5 and let two steps happen
        @(negedge clk);
        start = 1'b1; mode = M_SHR; shift_amt = 4'd5; ser_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (data_out !== 8'h3F || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_shr_progress: data=%h busy=%b, need 3f/1", data_out, busy);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_async: data=%h busy=%b done=%b ser=%b, need 00/0/0/0",
                     data_out, busy, done, ser_out);
        end
        dseen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) dseen++;
        end
        n_cmp++;
        if (dseen !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_no_done: done/busy seen %0d cycles, need 0", dseen);
        end
    endtask

    task automatic test_load();
        int bn, dn;
        logic fd;
        run_op(M_LOAD, 4'd3, 8'hAA, 1'b1, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'hAA || fd !== 1'b1 || dn !== 1 || bn !== 0) begin
            n_bad++;
            $display("FAIL load: data=%h first_done=%b done_n=%0d busy_n=%0d, need aa/1/1/0",
                     data_out, fd, dn, bn);
        end
    endtask

    task automatic test_shifts();
        int bn, dn;
        logic fd;
        run_op(M_SHL, 4'd3, 8'h00, 1'b0, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'h50 || ser_out !== 1'b1 || bn !== 3 || dn !== 1) begin
            n_bad++;
            $display("FAIL shl3: data=%h ser=%b busy_n=%0d done_n=%0d, need 50/1/3/1",
                     data_out, ser_out, bn, dn);
        end
        run_op(M_LOAD, 4'd0, 8'h90, 1'b0, bn, dn, fd);
        n_cmp++;
        if (ser_out !== 1'b1) begin
            n_bad++;
            $display("FAIL load_keeps_ser_out: ser=%b, need 1", ser_out);
        end
        run_op(M_ASR, 4'd2, 8'h00, 1'b0, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'hE4 || ser_out !== 1'b0 || bn !== 2) begin
            n_bad++;
            $display("FAIL asr2: data=%h ser=%b busy_n=%0d, need e4/0/2", data_out, ser_out, bn);
        end
        run_op(M_SHR, 4'd3, 8'h00, 1'b1, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'hFC || ser_out !== 1'b1 || bn !== 3) begin
            n_bad++;
            $display("FAIL shr3_fill1: data=%h ser=%b busy_n=%0d, need fc/1/3", data_out, ser_out, bn);
        end
        run_op(M_HOLD, 4'd4, 8'h00, 1'b0, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'hFC || ser_out !== 1'b1 || bn !== 0 || fd !== 1'b1 || dn !== 1) begin
            n_bad++;
            $display("FAIL hold: data=%h ser=%b busy_n=%0d first_done=%b done_n=%0d, need fc/1/0/1/1",
                     data_out, ser_out, bn, fd, dn);
        end
    endtask

    task automatic test_rotate();
        int bn, dn;
        logic fd;
        run_op(M_LOAD, 4'd0, 8'hA5, 1'b0, bn, dn, fd);
`ifdef USR_ROTATE_EN
        run_op(M_ROR, 4'd4, 8'h00, 1'b1, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'h5A || ser_out !== 1'b0 || bn !== 4 || dn !== 1) begin
            n_bad++;
            $display("FAIL ror4: data=%h ser=%b busy_n=%0d done_n=%0d, need 5a/0/4/1",
                     data_out, ser_out, bn, dn);
        end
`else
        run_op(M_ROR, 4'd4, 8'h00, 1'b1, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'hA5 || ser_out !== 1'b1 || bn !== 0 || fd !== 1'b1 || dn !== 1) begin
            n_bad++;
            $display("FAIL ror_disabled: data=%h ser=%b busy_n=%0d first_done=%b done_n=%0d, need a5/1/0/1/1",
                     data_out, ser_out, bn, fd, dn);
        end
`endif
    endtask

    task automatic test_boundaries();
        int bn, dn;
        logic fd;
        run_op(M_SHL, 4'd0, 8'h00, 1'b1, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'hA5 && data_out !== 8'h5A) begin
            n_bad++;
            $display("FAIL shl0_data: data=%h, need unchanged", data_out);
        end
        n_cmp++;
        if (fd !== 1'b1 || bn !== 0 || dn !== 1) begin
            n_bad++;
            $display("FAIL shl0_timing: first_done=%b busy_n=%0d done_n=%0d, need 1/0/1", fd, bn, dn);
        end
        run_op(M_LOAD, 4'd0, 8'hFF, 1'b0, bn, dn, fd);
        run_op(M_SHR, 4'd12, 8'h00, 1'b0, bn, dn, fd);
        n_cmp++;
        if (data_out !== 8'h00 || ser_out !== 1'b1 || bn !== 8 || dn !== 1) begin
            n_bad++;
            $display("FAIL shr12_clamp: data=%h ser=%b busy_n=%0d done_n=%0d, need 00/1/8/1",
                     data_out, ser_out, bn, dn);
        end
    endtask

    task automatic test_start_while_busy();
        int bn, dn, cyc;
        logic fd;
        run_op(M_LOAD, 4'd0, 8'h0F, 1'b0, bn, dn, fd);
        @(negedge clk);
        start = 1'b1; mode = M_SHL; shift_amt = 4'd4; ser_in = 1'b1;
        @(negedge clk);
        // re-request a LOAD of zero while the shift is running
        start = 1'b1; mode = M_LOAD; data_in = 8'h00;
        bn = 0;
        dn = 0;
        for (cyc = 0; cyc < 32; cyc++) begin
            if (cyc == 2) start = 1'b0;
            if (busy) bn++;
            if (done) dn++;
            if (dn > 0 && !done) break;
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (data_out !== 8'hFF || bn !== 4 || dn !== 1) begin
            n_bad++;
            $display("FAIL start_ignored_busy: data=%h busy_n=%0d done_n=%0d, need ff/4/1",
                     data_out, bn, dn);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        start = 1'b0;
        mode = M_HOLD;
        shift_amt = 4'd0;
        data_in = 8'h00;
        ser_in = 1'b0;
        test_reset();
        test_load();
        test_shifts();
        test_rotate();
        test_boundaries();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
